dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words in storage.
REQ-002 SHALL have parameter LATENCY, default 3: wait cycles between acceptance and response; legal range 1..15.
REQ-003 SHALL have port clk_i  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  1: CPU MEM-stage access request (MemRead or MemWrite).
REQ-006 SHALL have port we_i  input  1: 1 = write, 0 = read.
REQ-007 SHALL have port addr_i  input  32: byte address, from EX_MEM ALU result.
REQ-008 SHALL have port wdata_i  input  32: write data.
REQ-009 SHALL have port rdata_o  output  32: read data, valid while ack_o=1 on a read.
REQ-010 SHALL have port ack_o  output  1: one-cycle response strobe.
REQ-011 SHALL have port err_o  output  1: error flag, valid only while ack_o=1.
REQ-012 SHALL have port busy_o  output  1: pipeline stall request to the hazard logic.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP with a 4-bit down-counter cnt.
REQ-014 In IDLE, req_i=1 at a clock edge SHALL accept the request: latch we_i, addr_i, wdata_i; cnt <= LATENCY-1; state -> WAIT.
REQ-015 In WAIT, cnt!=0 SHALL decrement cnt; cnt==0 SHALL commit the access at that edge and move to RESP.
REQ-016 Commit SHALL be: read -> rdata_o <= mem[addr[31:2]]; write -> mem[addr[31:2]] <= wdata, rdata_o unchanged.
REQ-017 In RESP, ack_o SHALL be 1 for exactly that one cycle; next edge -> IDLE unconditionally.
REQ-018 Accept-to-ack latency SHALL be exactly LATENCY+1 edges: ack_o is high in the cycle following edge E0+LATENCY, where E0 is the accept edge.
REQ-019 req_i, we_i, addr_i, wdata_i SHALL be ignored in WAIT and RESP; only the values latched at acceptance are used.
REQ-020 A request held high through RESP SHALL NOT be re-accepted until the following IDLE cycle, so minimum request spacing is LATENCY+2 cycles.
REQ-021 busy_o SHALL equal (req_i & state==IDLE) | state==WAIT, combinationally; it SHALL be 0 in RESP so the pipeline advances on the ack edge.
REQ-022 Error condition SHALL be latched addr[1:0]!=0 or addr[31:2] >= DEPTH_WORDS.
REQ-023 On an error request, timing SHALL be unchanged, no memory write SHALL occur, rdata_o <= 0, and err_o=1 with ack_o.
REQ-024 err_o SHALL be 0 whenever ack_o=0.
REQ-025 Word index SHALL use addr[31:2]; no wrap-around; out-of-range is an error, never aliased.

Reset
REQ-026 rst_i=0 SHALL immediately force state=IDLE, cnt=0, ack_o=0, err_o=0, rdata_o=0, busy_o=req_i.
REQ-027 Reset during WAIT SHALL abort the request; no write SHALL be committed unless its commit edge preceded reset assertion.
REQ-028 Memory array contents SHALL NOT be reset.
REQ-029 The first request SHALL be accepted at the first rising edge with rst_i=1 and req_i=1.

Verification
REQ-030 Scenario: LATENCY=3, write 0xDEADBEEF to 0x10, then read 0x10 -> each ack_o arrives 4 edges after accept; read rdata_o=0xDEADBEEF, err_o=0.
REQ-031 Scenario: read addr 0x13 (misaligned) -> ack_o after 4 edges, err_o=1, rdata_o=0, mem[4] unchanged.
REQ-032 Scenario: DEPTH_WORDS=256, write to 0x400 -> err_o=1; mem[0] still holds its prior value 0x12345678 (no alias).
REQ-033 Scenario: req_i held high continuously, alternating addresses 0x0/0x4 -> accepts exactly every 5 cycles; busy_o=0 only in RESP cycles.
REQ-034 Scenario: change addr_i/wdata_i mid-WAIT -> the latched values are used; the later values have no effect.
REQ-035 Scenario: write 0xA5A5A5A5 to 0x8, assert rst_i=0 one cycle after accept -> no ack_o, all outputs 0; a read of 0x8 after reset does not return 0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU MEM stage.
// Accepts one request at a time, waits a fixed LATENCY, commits the access,
// then strobes ack_o for one cycle. busy_o stalls the pipeline meanwhile.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [3:0]         cnt;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic               err_q;
  logic               accept;
  logic               commit;
  logic               addr_bad;
  logic [IDX_W-1:0]   idx;
  logic [31:0]        mem [DEPTH_WORDS];

  // Request handshake points: acceptance only from IDLE, commit on the last WAIT edge.
  assign accept = (state == IDLE) && req_i;
  assign commit = (state == WAIT) && (cnt == 4'd0);

  // Misaligned or beyond the array is an error; out-of-range never aliases.
  assign addr_bad = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= DEPTH_LIM);
  assign idx      = addr_q[IDX_W+1:2];

  // State register; reset aborts any request in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> WAIT on accept, WAIT -> RESP at count zero, RESP -> IDLE always.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_i) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latency down-counter, loaded on accept and drained while waiting.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= CNT_INIT;
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Capture the request at acceptance; later input changes are ignored.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= we_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end

  // Response data and error flag, updated at the commit edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_o <= 32'd0;
      err_q   <= 1'b0;
    end else if (commit) begin
      err_q <= addr_bad;
      if (addr_bad) begin
        rdata_o <= 32'd0;
      end else if (!we_q) begin
        rdata_o <= mem[idx];
      end
    end
  end

  // Storage array is never reset; writes only for valid committed requests.
  always_ff @(posedge clk_i) begin
    if (commit && we_q && !addr_bad) begin
      mem[idx] <= wdata_q;
    end
  end

  assign ack_o  = (state == RESP);
  assign err_o  = ack_o && err_q;
  assign busy_o = (req_i && (state == IDLE)) || (state == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder with a word-level memory model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference: words written so far, keyed by word index.
  logic [31:0] model [int];
  logic [31:0] exp_rdata;
  bit          rdata_known;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req),
    .we_i   (we),
    .addr_i (addr),
    .wdata_i(wdata),
    .rdata_o(rdata),
    .ack_o  (ack),
    .err_o  (err),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
  endfunction

  // One full transaction: drive, expect ack exactly LAT+1 edges after accept.
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d, input string tag);
    bit e;
    int wi;
    e  = is_err(a);
    wi = int'(a >> 2);
    req = 1'b1; we = w; addr = a; wdata = d;
    #1;
    check1({tag, "_busy_req"}, busy, 1'b1);
    @(posedge clk); #1;
    for (int k = 0; k < LAT; k++) begin
      check1({tag, "_ack_wait"}, ack, 1'b0);
      check1({tag, "_busy_wait"}, busy, 1'b1);
      check1({tag, "_err_wait"}, err, 1'b0);
      req = 1'($urandom); we = 1'($urandom); addr = $urandom; wdata = $urandom;
      @(posedge clk); #1;
    end
    check1({tag, "_ack"}, ack, 1'b1);
    check1({tag, "_busy_resp"}, busy, 1'b0);
    check1({tag, "_err"}, err, e);
    if (e) begin
      exp_rdata = 32'd0; rdata_known = 1'b1;
    end else if (w) begin
      model[wi] = d;
    end else if (model.exists(wi)) begin
      exp_rdata = model[wi]; rdata_known = 1'b1;
    end else begin
      rdata_known = 1'b0;
    end
    if (rdata_known) check32({tag, "_rdata"}, rdata, exp_rdata);
    req = 1'b0;
    @(posedge clk); #1;
    check1({tag, "_ack_after"}, ack, 1'b0);
    check1({tag, "_err_after"}, err, 1'b0);
    check1({tag, "_busy_idle"}, busy, 1'b0);
  endtask

  initial begin
    logic [31:0] a_cur;
    logic [31:0] ra;
    int          sel;
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    exp_rdata = 32'd0; rdata_known = 1'b1;

    // Reset state
    #12;
    check1("rst_ack", ack, 1'b0);
    check1("rst_err", err, 1'b0);
    check32("rst_rdata", rdata, 32'd0);
    check1("rst_busy0", busy, 1'b0);
    req = 1'b1; #1;
    check1("rst_busy1", busy, 1'b1);
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Write then read back, misaligned read, out-of-range write (no alias)
    txn(1'b1, 32'h10, 32'hDEADBEEF, "wr10");
    txn(1'b0, 32'h10, 32'h0, "rd10");
    txn(1'b0, 32'h13, 32'h0, "rd13_mis");
    txn(1'b0, 32'h10, 32'h0, "rd10_again");
    txn(1'b1, 32'h0, 32'h12345678, "wr0");
    txn(1'b1, 32'h400, 32'hCAFEF00D, "wr400_oor");
    txn(1'b0, 32'h0, 32'h0, "rd0_noalias");
    txn(1'b1, 32'h4, 32'h44444444, "wr4");

    // Request held high: accepts every LAT+2 cycles, busy low only with ack
    a_cur = 32'h0;
    req = 1'b1; we = 1'b0; addr = a_cur;
    for (int n = 0; n < 3 * (LAT + 2); n++) begin
      @(posedge clk); #1;
      if ((n % (LAT + 2)) == LAT) begin
        check1("hold_ack", ack, 1'b1);
        check1("hold_busy_resp", busy, 1'b0);
        check1("hold_err", err, 1'b0);
        exp_rdata = model[int'(a_cur >> 2)];
        check32("hold_rdata", rdata, exp_rdata);
        a_cur = a_cur ^ 32'h4;
        addr = a_cur;
      end else begin
        check1("hold_ack_low", ack, 1'b0);
        check1("hold_busy", busy, 1'b1);
      end
    end
    req = 1'b0;
    @(posedge clk); #1;
    check1("hold_end_ack", ack, 1'b0);

    // Reset one cycle after accepting a write aborts it
    txn(1'b1, 32'h8, 32'h11111111, "wr8");
    req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check1("abort_ack", ack, 1'b0);
    check1("abort_err", err, 1'b0);
    check32("abort_rdata", rdata, 32'd0);
    check1("abort_busy0", busy, 1'b0);
    req = 1'b1; #1;
    check1("abort_busy1", busy, 1'b1);
    req = 1'b0;
    for (int k = 0; k < LAT + 1; k++) begin
      @(posedge clk); #1;
      check1("abort_no_ack", ack, 1'b0);
    end
    rst = 1'b1;
    exp_rdata = 32'd0; rdata_known = 1'b1;
    txn(1'b0, 32'h8, 32'h0, "rd8_after_abort");

    // Random mix of reads, writes and erroneous addresses
    for (int t = 0; t < 30; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 5)       ra = 32'($urandom_range(0, 15)) << 2;
      else if (sel < 7)  ra = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (sel == 7) ra = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 8) ra = 32'($urandom_range(DEPTH, DEPTH + 100)) << 2;
      else               ra = 32'hFFFF_FFFC;
      txn(1'($urandom), ra, $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
